// File: rtl/vpr_pkg.sv
// Shared marker defaults and FSM state types for the video packet receiver.
package vpr_pkg;

  localparam logic [3:0]  K_CTRL_DEF   = 4'b0001;
  localparam logic [31:0] SOF_WORD_DEF = 32'hFF0001BC;
  localparam logic [31:0] SOL_WORD_DEF = 32'hFF0002BC;

  typedef enum logic {
    W_IDLE,
    W_CAPT
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_LINE
  } rd_state_t;

endpackage

// File: rtl/vpr_line_fifo.sv
// Single-clock line buffer: speculative write pointer that is either committed
// (line complete) or rewound to the last commit (line discarded).
module vpr_line_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    commit,
  input  logic                    rewind,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp, cp, rp, wp_adv;
  logic              wr_ok, rd_ok;

  // Fullness is judged against the speculative pointer so a partial line
  // cannot overrun data the reader still owns.
  assign full   = (wp - rp) == CAP;
  assign empty  = (cp == rp);
  assign count  = cp - rp;
  assign wr_ok  = wr_en && !full && !flush;
  assign rd_ok  = rd_en && !empty && !flush;
  assign wp_adv = wr_ok ? wp + ONE : wp;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      cp      <= '0;
      rp      <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wp      <= '0;
      cp      <= '0;
      rp      <= '0;
      rd_data <= '0;
    end else begin
      wp <= rewind ? cp : wp_adv;
      if (commit) cp <= wp_adv;
      if (rd_ok) begin
        rd_data <= mem[rp[AW-1:0]];
        rp      <= rp + ONE;
      end
    end
  end

endmodule

// File: rtl/video_packet_rx_param.sv
// GT word stream receiver: detects SOF/SOL markers, buffers whole lines and
// replays them as a ready/valid pixel stream with a recovered frame sync.
module video_packet_rx_param
  import vpr_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CTRL_W     = 4,
  parameter int unsigned       PIX_W      = 16,
  parameter int unsigned       FIFO_DEPTH = 2048,
  parameter int unsigned       VS_LEN     = 100,
  parameter logic [CTRL_W-1:0] K_CTRL     = CTRL_W'(K_CTRL_DEF),
  parameter logic [DATA_W-1:0] SOF_WORD   = DATA_W'(SOF_WORD_DEF),
  parameter logic [DATA_W-1:0] SOL_WORD   = DATA_W'(SOL_WORD_DEF)
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] gt_rx_data,
  input  logic [CTRL_W-1:0] gt_rx_ctrl,
  input  logic [15:0]       vout_width,
  input  logic              vout_ready,
  output logic              vs,
  output logic              de,
  output logic [PIX_W-1:0]  vout_data,
  output logic [15:0]       line_cnt,
  output logic [15:0]       frame_cnt,
  output logic              err_ovf,
  output logic              err_short,
  input  logic              err_clr
);

  localparam int unsigned PPW = DATA_W / PIX_W;
  localparam int unsigned PIW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  logic              sof_now, sol_now, sof_q;
  logic [31:0]       vs_cnt;
  logic [15:0]       line_wpl;

  wr_state_t         w_state, w_next;
  logic [15:0]       wcnt, wcnt_next, wpl, wpl_next, cm_wpl;
  logic              f_wr, f_commit, f_rewind, set_short, set_ovf;

  rd_state_t         r_state, r_next;
  logic [15:0]       rd_words, rd_words_next;
  logic [PIW-1:0]    pix_idx, pix_next;
  logic [CW-1:0]     lines_avail;
  logic              f_rd, line_start;

  logic [DATA_W-1:0] fifo_q;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [PIX_W-1:0]  pix_sel;

  assign sof_now  = (gt_rx_ctrl == K_CTRL) && (gt_rx_data == SOF_WORD);
  assign sol_now  = (gt_rx_ctrl == K_CTRL) && (gt_rx_data == SOL_WORD);
  assign line_wpl = vout_width / 16'(PPW);

  vpr_line_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rx_clk),
    .rst_n   (rst_n),
    .flush   (sof_q),
    .wr_en   (f_wr),
    .wr_data (gt_rx_data),
    .commit  (f_commit),
    .rewind  (f_rewind),
    .rd_en   (f_rd),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Write side: capture WPL contiguous words after each SOL.
  always_comb begin
    w_next    = w_state;
    wcnt_next = wcnt;
    wpl_next  = wpl;
    f_wr      = 1'b0;
    f_commit  = 1'b0;
    f_rewind  = 1'b0;
    set_short = 1'b0;
    set_ovf   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (sol_now) begin
          w_next    = W_CAPT;
          wcnt_next = '0;
          wpl_next  = line_wpl;
        end
      end
      W_CAPT: begin
        if (sol_now) begin
          f_rewind  = 1'b1;
          set_short = 1'b1;
          wcnt_next = '0;
          wpl_next  = line_wpl;
        end else if (!sof_now) begin
          if (fifo_full) begin
            f_rewind = 1'b1;
            set_ovf  = 1'b1;
            w_next   = W_IDLE;
          end else begin
            f_wr = 1'b1;
            if (wcnt == wpl - 16'd1) begin
              f_commit = 1'b1;
              w_next   = W_IDLE;
            end else begin
              wcnt_next = wcnt + 16'd1;
            end
          end
        end
      end
    endcase
    if (sof_q) begin
      w_next    = W_IDLE;
      f_wr      = 1'b0;
      f_commit  = 1'b0;
      f_rewind  = 1'b0;
      set_short = 1'b0;
      set_ovf   = 1'b0;
    end
  end

  // Read side: the FIFO output register holds the current word; the next word
  // is popped on the transfer of the last pixel so lines stream without bubbles.
  always_comb begin
    r_next        = r_state;
    rd_words_next = rd_words;
    pix_next      = pix_idx;
    f_rd          = 1'b0;
    line_start    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (lines_avail != '0 && !fifo_empty) begin
          r_next        = R_LINE;
          f_rd          = 1'b1;
          line_start    = 1'b1;
          rd_words_next = cm_wpl;
          pix_next      = '0;
        end
      end
      R_LINE: begin
        if (vout_ready) begin
          if (pix_idx == PIW'(PPW - 1)) begin
            pix_next = '0;
            if (rd_words == 16'd1) begin
              r_next = R_IDLE;
            end else begin
              f_rd          = (fifo_count != '0);
              rd_words_next = rd_words - 16'd1;
            end
          end else begin
            pix_next = pix_idx + PIW'(1);
          end
        end
      end
    endcase
    if (sof_q) begin
      r_next     = R_IDLE;
      f_rd       = 1'b0;
      line_start = 1'b0;
    end
  end

  always_comb begin
    pix_sel = '0;
    for (int unsigned i = 0; i < PPW; i++) begin
      if (pix_idx == PIW'(i)) pix_sel = fifo_q[i*PIX_W +: PIX_W];
    end
  end

  assign de        = (r_state == R_LINE);
  assign vout_data = de ? pix_sel : '0;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_q  <= 1'b0;
      vs     <= 1'b0;
      vs_cnt <= '0;
    end else begin
      sof_q <= sof_now;
      if (sof_now) begin
        vs     <= 1'b1;
        vs_cnt <= VS_LEN - 1;
      end else if (vs) begin
        if (vs_cnt == '0) vs <= 1'b0;
        else              vs_cnt <= vs_cnt - 32'd1;
      end
    end
  end

  // Width for the read side is taken from the most recent commit.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wcnt     <= '0;
      wpl      <= '0;
      cm_wpl   <= '0;
      r_state  <= R_IDLE;
      rd_words <= '0;
      pix_idx  <= '0;
    end else begin
      w_state  <= w_next;
      wcnt     <= wcnt_next;
      wpl      <= wpl_next;
      r_state  <= r_next;
      rd_words <= rd_words_next;
      pix_idx  <= pix_next;
      if (f_commit) cm_wpl <= wpl;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_avail <= '0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
    end else if (sof_q) begin
      lines_avail <= '0;
      line_cnt    <= '0;
      frame_cnt   <= frame_cnt + 16'd1;
    end else begin
      if (f_commit && !line_start)      lines_avail <= lines_avail + CW'(1);
      else if (!f_commit && line_start) lines_avail <= lines_avail - CW'(1);
      if (line_start) line_cnt <= line_cnt + 16'd1;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf   <= 1'b0;
      err_short <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (set_short)    err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
    end
  end

endmodule
